// File: rtl/gc_table_streamer_pkg.sv
// Shared constants, gate codes and storage types for the garbled-table streamer.
// SKID tracks the GC_engine pipeline depth so issue_ok leaves room for gates already in flight.
package gc_table_streamer_pkg;

    localparam int K      = 128;
    localparam int S      = 32;
    localparam int W      = 32;
    localparam int NR_AES = 10;
    localparam int SKID   = NR_AES + 2;
    localparam int DEPTH  = 16;
    localparam int BEATS  = (2 * K) / W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef enum logic [3:0] {
        ANDGATE  = 4'd0,
        XORGATE  = 4'd1,
        XNORGATE = 4'd2,
        NOTGATE  = 4'd3,
        ORGATE   = 4'd4,
        NANDGATE = 4'd5,
        NORGATE  = 4'd6
    } gate_e;

    // rows = {gt_row_1, gt_row_0}, so beat 0 is the least significant word of row 0
    typedef struct packed {
        logic [S-1:0]   gid;
        logic [2*K-1:0] rows;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    function automatic logic is_free(input logic [3:0] code);
        return (code == XORGATE) || (code == XNORGATE) || (code == NOTGATE);
    endfunction

endpackage

// File: rtl/gc_table_streamer_if.sv
// Gate-result input bus plus the serialised table stream toward the host link.
// master = gate issuer / stream sink side, slave = the streamer itself.
interface gc_table_streamer_if;
    import gc_table_streamer_pkg::*;

    logic           in_valid;
    logic [3:0]     in_g_logic;
    logic [S-1:0]   in_gid;
    logic [K-1:0]   gt_row_0;
    logic [K-1:0]   gt_row_1;
    logic           issue_ok;

    logic [W-1:0]   out_data;
    logic [S-1:0]   out_gid;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;

    modport master (
        output in_valid, in_g_logic, in_gid, gt_row_0, gt_row_1, out_ready,
        input  issue_ok, out_data, out_gid, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_g_logic, in_gid, gt_row_0, gt_row_1, out_ready,
        output issue_ok, out_data, out_gid, out_valid, out_last
    );

endinterface

// File: rtl/gc_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module gc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: default assignment first, so no path leaves count_d unassigned and no latch is inferred.
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gc_table_streamer.sv
// Buffers garbled-table rows of non-free gates and serialises them as W-bit beats;
// free-XOR gates are only counted. issue_ok throttles the non-stallable GC_engine.
module gc_table_streamer
    import gc_table_streamer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    gc_table_streamer_if.slave  bus,
    output logic [31:0]         tables_sent,
    output logic [31:0]         free_gates,
    output logic                overflow
);

    logic              free_gate;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              last_accept;
    logic [CNT_W-1:0]  occupancy;
    entry_t            wr_entry;
    entry_t            head;

    state_e            state_q;
    entry_t            shifter_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic [W-1:0]      out_data_q;
    logic [S-1:0]      out_gid_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [31:0]       tables_sent_q;
    logic [31:0]       free_gates_q;
    logic              overflow_q;

    assign free_gate     = is_free(bus.in_g_logic);
    assign push_req      = bus.in_valid && !free_gate;
    assign wr_entry.gid  = bus.in_gid;
    assign wr_entry.rows = {bus.gt_row_1, bus.gt_row_0};
    assign last_accept   = out_valid_q && bus.out_ready && out_last_q;
    assign beat_d        = beat_q + BEAT_W'(1);

    // A pop happens only when the shifter is free or its last beat leaves this cycle.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            pop = (state_q == IDLE) || last_accept;
        end
    end

    gc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shifter_q     <= '0;
            beat_q        <= '0;
            out_data_q    <= '0;
            out_gid_q     <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            tables_sent_q <= '0;
            free_gates_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (bus.in_valid && free_gate) begin
                free_gates_q <= free_gates_q + 32'd1;
            end
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (last_accept) begin
                tables_sent_q <= tables_sent_q + 32'd1;
            end

            if (pop) begin
                // Load a fresh table; covers both IDLE start and back-to-back reload.
                state_q     <= SEND;
                shifter_q   <= head;
                beat_q      <= '0;
                out_data_q  <= head.rows[W-1:0];
                out_gid_q   <= head.gid;
                out_valid_q <= 1'b1;
                out_last_q  <= (BEATS == 1);
            end else if (state_q == SEND && bus.out_ready) begin
                if (out_last_q) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end else begin
                    beat_q     <= beat_d;
                    out_data_q <= shifter_q.rows[beat_d*W +: W];
                    out_last_q <= (beat_d == BEAT_W'(BEATS - 1));
                end
            end
        end
    end

    assign bus.issue_ok  = (occupancy <= CNT_W'(DEPTH - SKID));
    assign bus.out_data  = out_data_q;
    assign bus.out_gid   = out_gid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign tables_sent   = tables_sent_q;
    assign free_gates    = free_gates_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_gc_table_streamer.sv
// Self-checking bench for gc_table_streamer: beat scoreboard, gate-vector table
// and hand-written sequences for stalls, back-to-back tables, overflow and reset.
module tb_gc_table_streamer;
    import gc_table_streamer_pkg::*;

    typedef struct packed {
        logic [W-1:0] data;
        logic [S-1:0] gid;
        logic         last;
    } beat_t;

    typedef struct {
        logic [3:0]   code;
        logic [S-1:0] gid;
        logic [K-1:0] r0;
        logic [K-1:0] r1;
        bit           exp_free;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tables_sent;
    logic [31:0] free_gates;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    beat_t       sb[$];
    logic        stall_seen = 1'b0;
    beat_t       stall_beat;
    int          exp_tables = 0;
    int          exp_free_cnt = 0;

    always #5 clk = ~clk;

    gc_table_streamer_if bus ();

    gc_table_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tables_sent (tables_sent),
        .free_gates  (free_gates),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_table(input logic [S-1:0] gid, input logic [K-1:0] r0, input logic [K-1:0] r1);
        logic [2*K-1:0] rows;
        rows = {r1, r0};
        for (int i = 0; i < BEATS; i++) begin
            sb.push_back('{data: rows[i*W +: W], gid: gid, last: (i == BEATS - 1)});
        end
    endtask

    // Drives one in_valid cycle; expected beats go to the scoreboard when a table is expected.
    task automatic drive_gate(input logic [3:0] code, input logic [S-1:0] gid,
                              input logic [K-1:0] r0, input logic [K-1:0] r1, input bit expect_table);
        bus.in_valid   = 1'b1;
        bus.in_g_logic = code;
        bus.in_gid     = gid;
        bus.gt_row_0   = r0;
        bus.gt_row_1   = r1;
        if (expect_table) begin
            push_table(gid, r0, r1);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles, input bit toggle);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < max_cycles) begin
            bus.out_ready = toggle ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            step();
            n++;
        end
        bus.out_ready = 1'b1;
        check({name, "_drain_timeout"}, 64'(n >= max_cycles), 64'd0);
    endtask

    function automatic logic [K-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_data", bus.out_data, stall_beat.data);
                check("stall_hold_gid", bus.out_gid, stall_beat.gid);
                check("stall_hold_last", bus.out_last, stall_beat.last);
            end
            stall_seen <= 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 64'(sb.size()), 64'd1);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        check("beat_data", bus.out_data, e.data);
                        check("beat_gid", bus.out_gid, e.gid);
                        check("beat_last", bus.out_last, e.last);
                    end
                end else begin
                    stall_seen <= 1'b1;
                    stall_beat <= '{data: bus.out_data, gid: bus.out_gid, last: bus.out_last};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t           vecs[6];
        logic [K-1:0]   r0;
        logic [K-1:0]   r1;
        logic [2*K-1:0] rows;
        int             nvalid;

        vecs[0] = '{XORGATE,  32'd10, rand_row(), rand_row(), 1'b1};
        vecs[1] = '{XNORGATE, 32'd11, rand_row(), rand_row(), 1'b1};
        vecs[2] = '{NOTGATE,  32'd12, rand_row(), rand_row(), 1'b1};
        vecs[3] = '{ORGATE,   32'd13, rand_row(), rand_row(), 1'b0};
        vecs[4] = '{NANDGATE, 32'd14, rand_row(), rand_row(), 1'b0};
        vecs[5] = '{NORGATE,  32'd15, rand_row(), rand_row(), 1'b0};

        bus.in_valid   = 1'b0;
        bus.in_g_logic = '0;
        bus.in_gid     = '0;
        bus.gt_row_0   = '0;
        bus.gt_row_1   = '0;
        bus.out_ready  = 1'b1;
        rst            = 1'b1;
        repeat (3) step();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_gid", bus.out_gid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_issue_ok", bus.issue_ok, 1);
        check("rst_tables_sent", tables_sent, 0);
        check("rst_free_gates", free_gates, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        step();

        // Single AND table: two-cycle latency, 8 contiguous beats.
        drive_gate(ANDGATE, 32'd5, 128'h0F, 128'hF000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
        @(negedge clk);
        check("t1_latency_cycle1", bus.out_valid, 0);
        @(negedge clk);
        check("t1_latency_cycle2", bus.out_valid, 1);
        check("t1_beat0_data", bus.out_data, 32'h0000_000F);
        check("t1_gid", bus.out_gid, 5);
        nvalid = 1;
        repeat (BEATS - 1) begin
            @(negedge clk);
            nvalid += int'(bus.out_valid);
        end
        check("t1_beat7_data", bus.out_data, 32'hF000_0000);
        check("t1_contiguous", nvalid, BEATS);
        @(negedge clk);
        check("t1_idle_after", bus.out_valid, 0);
        exp_tables++;
        check("t1_tables_sent", tables_sent, exp_tables);
        step();

        // Gate vector table: free gates are counted only, others stream a table.
        for (int i = 0; i < 6; i++) begin
            drive_gate(vecs[i].code, vecs[i].gid, vecs[i].r0, vecs[i].r1, !vecs[i].exp_free);
            repeat (2) @(negedge clk);
            check("vec_out_valid", bus.out_valid, !vecs[i].exp_free);
            step();
            wait_drain("vec", 50, 1'b0);
            exp_free_cnt += int'(vecs[i].exp_free);
            exp_tables   += int'(!vecs[i].exp_free);
            check("vec_free_gates", free_gates, exp_free_cnt);
            check("vec_tables_sent", tables_sent, exp_tables);
        end

        // Stalling sink: ready toggles 1,0,0,1.
        drive_gate(ANDGATE, 32'd20, rand_row(), rand_row(), 1'b1);
        wait_drain("t3", 200, 1'b1);
        exp_tables++;
        check("t3_tables_sent", tables_sent, exp_tables);

        // Back-to-back tables: 16 contiguous beats, no bubble.
        drive_gate(ANDGATE, 32'd30, rand_row(), rand_row(), 1'b1);
        drive_gate(ANDGATE, 32'd31, rand_row(), rand_row(), 1'b1);
        nvalid = 0;
        repeat (2 * BEATS) begin
            @(negedge clk);
            nvalid += int'(bus.out_valid);
        end
        check("t4_contiguous", nvalid, 2 * BEATS);
        @(negedge clk);
        check("t4_idle_after", bus.out_valid, 0);
        exp_tables += 2;
        check("t4_tables_sent", tables_sent, exp_tables);
        step();

        // Backpressure: issue_ok threshold, fill, overflow, then drain 17 tables.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_gate(ANDGATE, 32'(100 + k), rand_row(), rand_row(), 1'b1);
        end
        @(negedge clk);
        check("t5_issue_ok_occ4", bus.issue_ok, 1);
        step();
        drive_gate(ANDGATE, 32'd105, rand_row(), rand_row(), 1'b1);
        @(negedge clk);
        check("t5_issue_ok_occ5", bus.issue_ok, 0);
        step();
        for (int k = 6; k < 17; k++) begin
            drive_gate(ANDGATE, 32'(100 + k), rand_row(), rand_row(), 1'b1);
        end
        @(negedge clk);
        check("t5_overflow_before", overflow, 0);
        step();
        drive_gate(ANDGATE, 32'd117, rand_row(), rand_row(), 1'b0);
        @(negedge clk);
        check("t5_overflow_after", overflow, 1);
        check("t5_issue_ok_full", bus.issue_ok, 0);
        step();
        wait_drain("t5", 400, 1'b0);
        exp_tables += 17;
        check("t5_tables_sent", tables_sent, exp_tables);
        check("t5_overflow_sticky", overflow, 1);
        check("t5_issue_ok_empty", bus.issue_ok, 1);

        // Reset during beat 3 abandons the table.
        r0   = rand_row();
        r1   = rand_row();
        rows = {r1, r0};
        drive_gate(ANDGATE, 32'd40, r0, r1, 1'b1);
        repeat (4) step();
        check("t6_on_beat3", bus.out_data, rows[3*W +: W]);
        rst = 1'b1;
        sb.delete();
        step();
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_tables_sent", tables_sent, 0);
        check("t6_free_gates", free_gates, 0);
        check("t6_overflow", overflow, 0);
        check("t6_issue_ok", bus.issue_ok, 1);
        rst = 1'b0;
        exp_tables   = 0;
        exp_free_cnt = 0;
        drive_gate(ANDGATE, 32'd41, rand_row(), rand_row(), 1'b1);
        wait_drain("t6", 50, 1'b0);
        exp_tables++;
        check("t6_tables_after", tables_sent, exp_tables);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
